// File: rtl/mips_exec_datapath.sv
// MiniMIPS execute slice: dest-register mux, operand-B mux, 32-bit ALU and a one-stage output register.
// Define MINIMIPS_ALU_SHIFT_EN to build the SLL shifter; otherwise alu_ctrl=101 returns zero.
module mips_exec_datapath #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_dest,
  input  logic [WIDTH-1:0]   read_data1,
  input  logic [WIDTH-1:0]   read_data2,
  input  logic [WIDTH-1:0]   imm32,
  input  logic               alu_src,
  input  logic [2:0]         alu_ctrl,
  input  logic               carry_in,
  output logic [RADDR_W-1:0] write_reg,
  output logic [WIDTH-1:0]   alu_result,
  output logic               zero,
  output logic               overflow,
  output logic [RADDR_W-1:0] write_reg_q,
  output logic [WIDTH-1:0]   alu_result_q,
  output logic               zero_q,
  output logic               overflow_q,
  output logic               valid_q
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] cin_ext;
  alu_op_e          op;

  assign write_reg = reg_dest ? rd_addr : rt_addr;
  assign op_a      = read_data1;
  assign op_b      = alu_src ? imm32 : read_data2;
  assign cin_ext   = {{(WIDTH-1){1'b0}}, carry_in};
  assign op        = alu_op_e'(alu_ctrl);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    alu_result = '0;
    overflow   = 1'b0;
    case (op)
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_ADD: begin
        alu_result = op_a + op_b + cin_ext;
        overflow   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_result[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_NOR: alu_result = ~(op_a | op_b);
`ifdef MINIMIPS_ALU_SHIFT_EN
      ALU_SLL: alu_result = op_b << op_a[4:0];
`else
      ALU_SLL: alu_result = '0;
`endif
      ALU_SUB: begin
        alu_result = op_a - op_b;
        overflow   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_result[WIDTH-1] != op_a[WIDTH-1]);
      end
      // Signed compare rather than the subtract sign bit, so SLT stays right when A-B overflows.
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  logic [RADDR_W-1:0] write_reg_d;
  logic [WIDTH-1:0]   alu_result_d;
  logic               zero_d;
  logic               overflow_d;
  logic               valid_d;

  always_comb begin
    write_reg_d  = write_reg_q;
    alu_result_d = alu_result_q;
    zero_d       = zero_q;
    overflow_d   = overflow_q;
    valid_d      = en;
    if (en) begin
      write_reg_d  = write_reg;
      alu_result_d = alu_result;
      zero_d       = zero;
      overflow_d   = overflow;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg_q  <= '0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      write_reg_q  <= write_reg_d;
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_mips_exec_datapath.sv
// Scoreboard bench for mips_exec_datapath: combinational outputs checked per vector,
// captured results queued at drive time and popped when valid_q rises.
module tb_mips_exec_datapath;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  rt_addr;
  logic [2:0]  rd_addr;
  logic        reg_dest;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] imm32;
  logic        alu_src;
  logic [2:0]  alu_ctrl;
  logic        carry_in;
  logic [2:0]  write_reg;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;
  logic [2:0]  write_reg_q;
  logic [31:0] alu_result_q;
  logic        zero_q;
  logic        overflow_q;
  logic        valid_q;

  mips_exec_datapath #(.WIDTH(32), .RADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .rt_addr      (rt_addr),
    .rd_addr      (rd_addr),
    .reg_dest     (reg_dest),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .imm32        (imm32),
    .alu_src      (alu_src),
    .alu_ctrl     (alu_ctrl),
    .carry_in     (carry_in),
    .write_reg    (write_reg),
    .alu_result   (alu_result),
    .zero         (zero),
    .overflow     (overflow),
    .write_reg_q  (write_reg_q),
    .alu_result_q (alu_result_q),
    .zero_q       (zero_q),
    .overflow_q   (overflow_q),
    .valid_q      (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zro;
    logic        ovf;
    logic [2:0]  wr;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_cap;
  int   total = 0;
  int   bad   = 0;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_XOR = 3'b011,
                         OP_NOR = 3'b100, OP_SLL = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Independent reference: wide signed arithmetic, overflow from range check.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                input logic cin, output logic [31:0] r, output logic ovf);
    int     sa;
    int     sb;
    longint s;
    sa  = a;
    sb  = b;
    ovf = 1'b0;
    r   = 32'd0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        s   = longint'(sa) + longint'(sb) + longint'(cin);
        r   = s[31:0];
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_SLL: begin
`ifdef MINIMIPS_ALU_SHIFT_EN
        s = longint'({32'd0, b}) * (64'sd1 <<< a[4:0]);
        r = s[31:0];
`else
        r = 32'd0;
`endif
      end
      OP_SUB: begin
        s   = longint'(sa) - longint'(sb);
        r   = s[31:0];
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic drive(input string tag, input logic rst_v, input logic en_v,
                       input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic src, input logic [2:0] op, input logic cin,
                       input logic [2:0] rt, input logic [2:0] rd, input logic dest,
                       input logic [31:0] exp_r, input logic exp_ovf);
    exp_t e;
    rst        = rst_v;
    en         = en_v;
    read_data1 = a;
    read_data2 = rd2;
    imm32      = imm;
    alu_src    = src;
    alu_ctrl   = op;
    carry_in   = cin;
    rt_addr    = rt;
    rd_addr    = rd;
    reg_dest   = dest;
    #1;
    e.res = exp_r;
    e.zro = (exp_r == 32'd0);
    e.ovf = exp_ovf;
    e.wr  = dest ? rd : rt;
    check({tag, "_res"},  alu_result, e.res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zro});
    check({tag, "_ovf"},  {31'd0, overflow}, {31'd0, e.ovf});
    check({tag, "_wr"},   {29'd0, write_reg}, {29'd0, e.wr});
    if (en_v && !rst_v) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst_v) begin
      last_cap = '0;
      check({tag, "_rst_valid"}, {31'd0, valid_q}, 32'd0);
      check({tag, "_rst_res"},   alu_result_q, 32'd0);
      check({tag, "_rst_flags"}, {29'd0, zero_q, overflow_q, 1'b0}, 32'd0);
      check({tag, "_rst_wr"},    {29'd0, write_reg_q}, 32'd0);
    end else begin
      check({tag, "_valid"}, {31'd0, valid_q}, {31'd0, en_v});
      if (valid_q) begin
        if (exp_q.size() == 0) begin
          check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          last_cap = exp_q.pop_front();
        end
      end
      check({tag, "_q_res"},  alu_result_q, last_cap.res);
      check({tag, "_q_zero"}, {31'd0, zero_q}, {31'd0, last_cap.zro});
      check({tag, "_q_ovf"},  {31'd0, overflow_q}, {31'd0, last_cap.ovf});
      check({tag, "_q_wr"},   {29'd0, write_reg_q}, {29'd0, last_cap.wr});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ri;
    logic [31:0] er;
    logic        eo;
    logic [2:0]  rop;
    logic        rsrc;
    logic        rcin;
    logic        ren;
    logic [31:0] sll_exp;
    last_cap = '0;

    // Reset has priority over en; the next cycle captures normally.
    drive("rst_hold",  1'b1, 1'b1, 32'd5, 32'd3, 32'd0, 1'b0, OP_ADD, 1'b0, 3'd0, 3'd0, 1'b0, 32'd8, 1'b0);
    drive("rst_rel",   1'b0, 1'b1, 32'd5, 32'd3, 32'd0, 1'b0, OP_ADD, 1'b0, 3'd0, 3'd0, 1'b0, 32'd8, 1'b0);

    drive("mux_rt",    1'b0, 1'b1, 32'd10, 32'd7, 32'hFFFF_FFFC, 1'b0, OP_ADD, 1'b0, 3'b010, 3'b101, 1'b0, 32'd17, 1'b0);
    drive("mux_rd",    1'b0, 1'b1, 32'd10, 32'd7, 32'hFFFF_FFFC, 1'b1, OP_ADD, 1'b0, 3'b010, 3'b101, 1'b1, 32'd6, 1'b0);

    drive("add_ovf",   1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, OP_ADD, 1'b0, 3'd1, 3'd2, 1'b0, 32'h8000_0000, 1'b1);
    drive("sub_zero",  1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 1'b0, OP_SUB, 1'b0, 3'd1, 3'd2, 1'b1, 32'd0, 1'b0);
    drive("add_cin",   1'b0, 1'b1, 32'd1, 32'd1, 32'd0, 1'b0, OP_ADD, 1'b1, 3'd3, 3'd4, 1'b0, 32'd3, 1'b0);
    drive("sub_cin",   1'b0, 1'b1, 32'd9, 32'd4, 32'd0, 1'b0, OP_SUB, 1'b1, 3'd3, 3'd4, 1'b0, 32'd5, 1'b0);
    drive("sub_ovf",   1'b0, 1'b1, 32'h8000_0000, 32'd1, 32'd0, 1'b0, OP_SUB, 1'b0, 3'd6, 3'd7, 1'b1, 32'h7FFF_FFFF, 1'b1);

    drive("and",       1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, OP_AND, 1'b0, 3'd1, 3'd6, 1'b1, 32'h00F0_00F0, 1'b0);
    drive("or",        1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, OP_OR,  1'b0, 3'd1, 3'd6, 1'b0, 32'hFFF0_FFF0, 1'b0);
    drive("xor",       1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, OP_XOR, 1'b0, 3'd1, 3'd6, 1'b1, 32'hFF00_FF00, 1'b0);
    drive("nor",       1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, OP_NOR, 1'b0, 3'd1, 3'd6, 1'b0, 32'h000F_000F, 1'b0);
    drive("slt_neg",   1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, OP_SLT, 1'b0, 3'd2, 3'd3, 1'b0, 32'd1, 1'b0);
    drive("slt_ovf",   1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0, OP_SLT, 1'b0, 3'd2, 3'd3, 1'b1, 32'd1, 1'b0);
    drive("slt_false", 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, OP_SLT, 1'b0, 3'd2, 3'd3, 1'b1, 32'd0, 1'b0);

`ifdef MINIMIPS_ALU_SHIFT_EN
    sll_exp = 32'h30;
`else
    sll_exp = 32'd0;
`endif
    drive("sll",       1'b0, 1'b1, 32'd4, 32'd3, 32'd0, 1'b0, OP_SLL, 1'b0, 3'd5, 3'd1, 1'b0, sll_exp, 1'b0);
`ifdef MINIMIPS_ALU_SHIFT_EN
    sll_exp = 32'h1234_5679;
`endif
    drive("sll_by0",   1'b0, 1'b1, 32'd0, 32'h1234_5679, 32'd0, 1'b0, OP_SLL, 1'b0, 3'd5, 3'd1, 1'b0, sll_exp, 1'b0);
`ifdef MINIMIPS_ALU_SHIFT_EN
    sll_exp = 32'h8000_0000;
`endif
    drive("sll_by31",  1'b0, 1'b1, 32'd31, 32'h0000_0003, 32'd0, 1'b0, OP_SLL, 1'b0, 3'd5, 3'd1, 1'b0, sll_exp, 1'b0);

    // Capture 2+2, then hold through three cycles of en=0 while inputs change.
    drive("hold_cap",  1'b0, 1'b1, 32'd2, 32'd2, 32'd0, 1'b0, OP_ADD, 1'b0, 3'd4, 3'd7, 1'b1, 32'd4, 1'b0);
    for (int i = 0; i < 3; i++)
      drive("hold",    1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0, OP_ADD, 1'b0, 3'd1, 3'd2, 1'b0, 32'd18, 1'b0);

    // Reset arriving with a capture pending discards it.
    drive("mid_rst",   1'b1, 1'b1, 32'd6, 32'd1, 32'd0, 1'b0, OP_SUB, 1'b0, 3'd7, 3'd7, 1'b0, 32'd5, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra   = $urandom();
      rb   = $urandom();
      ri   = $urandom();
      rop  = 3'($urandom_range(0, 7));
      rsrc = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      ren  = ($urandom_range(0, 3) != 0);
      if (i % 6 == 0) rb = ra;
      if (rop == OP_SLL) ra = {27'd0, ra[4:0]};
      model(ra, rsrc ? ri : rb, rop, (rop == OP_ADD) ? rcin : 1'b0, er, eo);
      drive("rand", 1'b0, ren, ra, rb, ri, rsrc, rop, rcin,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), er, eo);
    end

    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_exec_datapath.md
Name: mips_exec_datapath

Overview:
- Single-cycle MiniMIPS execute slice, sitting between register-file read and data-memory/write-back.
- Combines the destination-register select mux (3-bit), the ALU operand-B mux (32-bit: register or sign-extended immediate) and a 32-bit ALU with a carry-in.
- Results are available combinationally and through a one-stage output register used by write-back and branch logic.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- RADDR_W, 3, register-address width (8-entry register file).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable for the output register.
- rt_addr  in  RADDR_W  rt field (instr[8:6]).
- rd_addr  in  RADDR_W  rd field (instr[5:3]).
- reg_dest  in  1  0 selects rt_addr, 1 selects rd_addr.
- read_data1  in  WIDTH  ALU operand A (rs value).
- read_data2  in  WIDTH  rt value.
- imm32  in  WIDTH  sign-extended immediate.
- alu_src  in  1  0 selects read_data2, 1 selects imm32 for operand B.
- alu_ctrl  in  3  operation select.
- carry_in  in  1  carry into ADD (MiniMIPS top ties it to 0).
- write_reg  out  RADDR_W  combinational mux result.
- alu_result  out  WIDTH  combinational ALU result.
- zero  out  1  combinational, alu_result == 0.
- overflow  out  1  combinational signed overflow.
- write_reg_q  out  RADDR_W  registered write_reg.
- alu_result_q  out  WIDTH  registered alu_result.
- zero_q  out  1  registered zero.
- overflow_q  out  1  registered overflow.
- valid_q  out  1  high the cycle after a capture.

Behaviour:
- Muxes are purely combinational:
  - write_reg = reg_dest ? rd_addr : rt_addr.
  - B = alu_src ? imm32 : read_data2.
  - A = read_data1.
- alu_ctrl encoding; all arithmetic is modulo 2^WIDTH:
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B + carry_in.
  - 011 XOR: A ^ B.
  - 100 NOR: ~(A | B).
  - 101 SLL: B << A[4:0]; see Optional Feature.
  - 110 SUB: A - B, i.e. A + ~B + 1; carry_in ignored.
  - 111 SLT: 1 if signed A < signed B, else 0. Computed by signed comparison, not from the subtract sign bit, so it is correct on overflow.
- overflow:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- zero is asserted whenever alu_result == 0, for every op.
- Output register, on rising clk:
  - rst=1: write_reg_q=0, alu_result_q=0, zero_q=0, overflow_q=0, valid_q=0. Reset has priority over en.
  - rst=0, en=1: capture the combinational values; valid_q=1.
  - rst=0, en=0: hold all registered outputs; valid_q=0.
- Latency: 0 cycles on the combinational outputs, 1 cycle on the _q outputs.
- Reset asserted mid-operation discards the pending capture.
- No X propagation: unknown alu_ctrl cannot occur (3-bit code fully decoded).

Optional Feature:
- Macro MINIMIPS_ALU_SHIFT_EN.
- Defined: alu_ctrl=101 performs the logical left shift B << A[4:0]; shift amounts of 0 pass B unchanged, and 31 keeps only B[0] at bit 31.
- Undefined: alu_ctrl=101 yields alu_result=0 (zero=1, overflow=0), and no shifter is synthesized.

Test Plan:
- Reset: rst=1 with en=1 and A=5, B=3, ADD for one clk -> all _q outputs 0, valid_q=0. Next clk with rst=0 -> alu_result_q=8, valid_q=1.
- Muxes: rt=3'b010, rd=3'b101; reg_dest=0 -> write_reg=2, reg_dest=1 -> write_reg=5. read_data2=7, imm32=0xFFFFFFFC; alu_src=0 then 1 with A=10, ADD -> 17, then 6.
- Arithmetic: A=0x7FFFFFFF, B=1, ADD, carry_in=0 -> 0x80000000, overflow=1. A=5, B=5, SUB -> 0, zero=1, overflow=0. A=1, B=1, carry_in=1, ADD -> 3.
- Logic/SLT: A=0xF0F0F0F0, B=0x0FF00FF0 -> AND 0x00F000F0, OR 0xFFF0FFF0, XOR 0xFF00FF00, NOR 0x000F000F. SLT with A=0xFFFFFFFF (-1), B=1 -> 1. SLT with A=0x80000000, B=0x7FFFFFFF -> 1.
- Enable hold: capture ADD 2+2=4 with en=1, then change inputs to 9+9 with en=0 for 3 clks -> alu_result_q stays 4, valid_q=0.
- Shift: alu_ctrl=101, A=4, B=3 -> 0x30 with MINIMIPS_ALU_SHIFT_EN defined; 0 with zero=1 when undefined.
